// File: rtl/game_state_controller.sv
// ---------------------------------------------------------------------------
// game_state_controller
//
// Purpose:
//   Top-level game flow sequencer. It moves between the start screen,
//   active play, pause and the end screen. It also raises a one-clock
//   game_over pulse, applies a frame-counted lockout before a restart is
//   accepted, and optionally tracks the best score since reset.
//
// Configuration macro:
//   HIGH_SCORE_EN - when defined, a high-score register is built. When it
//                   is undefined, high_score is tied to zero.
//
// Parameters:
//   END_LOCK_FRAMES - frame_tick pulses during which the end screen
//                     ignores start_btn after it is entered
//   SCORE_W         - width of score / high_score
//
// Ports:
//   clk           in   system clock; all state changes on its rising edge
//   rst           in   asynchronous, active-low reset
//   frame_tick    in   one-clk pulse per display frame (lockout timebase)
//   start_btn     in   debounced level, high = pressed
//   pause_btn     in   debounced level, high = pressed
//   collision     in   level, high = bird overlaps pipe or ground
//   score         in   current score from the pipes block
//   game_state    out  one-hot {END, PAUSE, IN_GAME, START}
//   game_over     out  one-clk pulse on entry to the end screen
//   high_score    out  best score since reset (0 without HIGH_SCORE_EN)
//   restart_ready out  high in the end screen once the lockout expired
// ---------------------------------------------------------------------------
module game_state_controller #(
    parameter int END_LOCK_FRAMES = 60,
    parameter int SCORE_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         game_state,
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score,
    output logic               restart_ready
);

    // A lockout of zero frames still needs a one-bit counter.
    localparam int LOCK_W = (END_LOCK_FRAMES < 1) ? 1 : $clog2(END_LOCK_FRAMES + 1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(END_LOCK_FRAMES);

    typedef enum logic [3:0] {
        ST_START = 4'b0001,
        ST_GAME  = 4'b0010,
        ST_PAUSE = 4'b0100,
        ST_END   = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              game_over_q, game_over_d;
    logic              start_prev_q, start_prev_d;
    logic              pause_prev_q, pause_prev_d;

    logic start_press;
    logic pause_press;
    logic end_entry;

    // The history flops reset to 1. A button held through reset release
    // therefore has to be released and pressed again before it counts.
    assign start_press   = start_btn & ~start_prev_q;
    assign pause_press   = pause_btn & ~pause_prev_q;
    assign start_prev_d  = start_btn;
    assign pause_prev_d  = pause_btn;

    assign restart_ready = (state_q == ST_END) && (lock_q == '0);
    assign game_state    = state_q;
    assign game_over     = game_over_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_START;
            lock_q       <= '0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            game_over_q  <= game_over_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        end_entry = 1'b0;
        case (state_q)
            ST_START: begin
                if (start_press) state_d = ST_GAME;
            end
            ST_GAME: begin
                // If collision and pause arrive together, collision wins.
                if (collision) begin
                    state_d   = ST_END;
                    end_entry = 1'b1;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press) state_d = ST_GAME;
            end
            ST_END: begin
                // A press during the lockout is dropped, not remembered.
                if (start_press && restart_ready) state_d = ST_START;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // The counter loads on the entry edge, so a frame_tick in that same
    // clock does not shorten the lockout. The counter reads zero outside
    // the end screen.
    always_comb begin
        lock_d      = lock_q;
        game_over_d = end_entry;
        if (end_entry) begin
            lock_d = LOCK_INIT;
        end else if (state_q == ST_END) begin
            if (frame_tick && (lock_q != '0)) lock_d = lock_q - LOCK_W'(1);
        end else begin
            lock_d = '0;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q, high_score_d;

    always_comb begin
        high_score_d = high_score_q;
        if (end_entry && (score > high_score_q)) high_score_d = score;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) high_score_q <= '0;
        else      high_score_q <= high_score_d;
    end

    assign high_score = high_score_q;
`else
    // Without the high-score feature, score has no consumer.
    logic score_unused;
    assign score_unused = ^score;
    assign high_score   = '0;
`endif

endmodule

// File: tb/tb_game_state_controller.sv
// ---------------------------------------------------------------------------
// tb_game_state_controller
//
// Self-checking bench for game_state_controller (END_LOCK_FRAMES = 4).
// The reference model tracks the game as a scene number, a lockout frame
// count and a best score. The expected one-hot state is derived as
// 1 << scene. Directed scenarios come first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_game_state_controller;

    localparam int LOCK  = 4;
    localparam int SW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          pause_btn = 1'b0;
    logic          collision = 1'b0;
    logic [SW-1:0] score = '0;
    logic [3:0]    game_state;
    logic          game_over;
    logic [SW-1:0] high_score;
    logic          restart_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model. Scenes: 0 start, 1 playing, 2 paused, 3 end.
    int            m_scene;
    int            m_frames_left;
    int unsigned   m_best;
    bit            m_over;
    bit            m_last_start;
    bit            m_last_pause;

    game_state_controller #(
        .END_LOCK_FRAMES(LOCK),
        .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .collision(collision),
        .score(score),
        .game_state(game_state),
        .game_over(game_over),
        .high_score(high_score),
        .restart_ready(restart_ready)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        m_scene       = 0;
        m_frames_left = 0;
        m_best        = 0;
        m_over        = 1'b0;
        m_last_start  = 1'b1;
        m_last_pause  = 1'b1;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit start_hit, pause_hit;
        start_hit = start_btn && !m_last_start;
        pause_hit = pause_btn && !m_last_pause;
        m_over    = 1'b0;
        if (m_scene == 0) begin
            if (start_hit) m_scene = 1;
        end else if (m_scene == 1) begin
            if (collision) begin
                m_scene       = 3;
                m_over        = 1'b1;
                m_frames_left = LOCK;
`ifdef HIGH_SCORE_EN
                if (score > m_best) m_best = score;
`endif
            end else if (pause_hit) begin
                m_scene = 2;
            end
        end else if (m_scene == 2) begin
            if (pause_hit) m_scene = 1;
        end else begin
            if (start_hit && m_frames_left == 0) m_scene = 0;
            else if (frame_tick && m_frames_left > 0) m_frames_left = m_frames_left - 1;
        end
        m_last_start = start_btn;
        m_last_pause = pause_btn;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] exp_state;
        exp_state = 4'(1 << m_scene);
        checkValue({tag, ".state"}, 32'(game_state), 32'(exp_state));
        checkValue({tag, ".over"}, 32'(game_over), 32'(m_over));
        checkValue({tag, ".high"}, high_score, m_best);
        checkValue({tag, ".ready"}, 32'(restart_ready), 32'((m_scene == 3) && (m_frames_left == 0)));
    endtask

    // One clock: drive on the falling edge, sample just after the rising edge.
    task automatic applyStimulus(input string tag, input bit s, input bit p, input bit c,
                                 input bit f, input logic [SW-1:0] sc);
        @(negedge clk);
        start_btn  = s;
        pause_btn  = p;
        collision  = c;
        frame_tick = f;
        score      = sc;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Finishes one game at the given score, then waits out the lockout
    // and returns to the start screen.
    task automatic playGame(input string tag, input logic [SW-1:0] sc);
        applyStimulus({tag, ".start"}, 1, 0, 0, 0, sc);
        applyStimulus({tag, ".rel"}, 0, 0, 0, 0, sc);
        applyStimulus({tag, ".hit"}, 0, 0, 1, 0, sc);
        checkValue({tag, ".pulse"}, 32'(game_over), 32'd1);
        for (int i = 0; i < LOCK; i++) applyStimulus({tag, ".tick"}, 0, 0, 0, 1, sc);
        applyStimulus({tag, ".restart"}, 1, 0, 0, 0, sc);
        applyStimulus({tag, ".rel2"}, 0, 0, 0, 0, sc);
    endtask

    initial begin
        // Reset, with start held through the release.
        start_btn = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset");
        checkValue("reset.state_const", 32'(game_state), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("held_start", 1, 0, 0, 0, 0);
        checkValue("held_start.no_press", 32'(game_state), 32'h1);
        applyStimulus("start_rel", 0, 0, 0, 0, 0);
        applyStimulus("start_press", 1, 0, 0, 0, 0);
        checkValue("start_press.ingame", 32'(game_state), 32'h2);

        // Pause, a collision while paused, then resume.
        applyStimulus("pause_on", 0, 1, 0, 0, 0);
        checkValue("pause_on.const", 32'(game_state), 32'h4);
        for (int i = 0; i < 5; i++) applyStimulus("pause_coll", 0, 0, 1, 0, 0);
        checkValue("pause_coll.const", 32'(game_state), 32'h4);
        applyStimulus("pause_off", 0, 1, 0, 0, 0);
        checkValue("pause_off.const", 32'(game_state), 32'h2);
        applyStimulus("pause_rel", 0, 0, 0, 0, 0);

        // Collision and pause rising in the same clock, score 7.
        applyStimulus("coll_pause", 0, 1, 1, 0, 7);
        checkValue("coll_pause.end", 32'(game_state), 32'h8);
        checkValue("coll_pause.pulse", 32'(game_over), 32'd1);
        applyStimulus("coll_pause.after", 0, 0, 0, 0, 7);
        checkValue("coll_pause.pulse_gone", 32'(game_over), 32'd0);

        // Lockout: a press after 2 ticks is dropped; ready after the 4th tick.
        applyStimulus("lock_tick1", 0, 0, 0, 1, 7);
        applyStimulus("lock_tick2", 0, 0, 0, 1, 7);
        applyStimulus("lock_early", 1, 0, 0, 0, 7);
        checkValue("lock_early.ignored", 32'(game_state), 32'h8);
        applyStimulus("lock_rel", 0, 0, 0, 0, 7);
        applyStimulus("lock_tick3", 0, 0, 0, 1, 7);
        checkValue("lock_tick3.not_ready", 32'(restart_ready), 32'd0);
        applyStimulus("lock_tick4", 0, 0, 0, 1, 7);
        checkValue("lock_tick4.ready", 32'(restart_ready), 32'd1);
        applyStimulus("lock_restart", 1, 0, 0, 0, 7);
        checkValue("lock_restart.start", 32'(game_state), 32'h1);
        applyStimulus("lock_rel2", 0, 0, 0, 0, 7);
`ifdef HIGH_SCORE_EN
        checkValue("hs_game1", high_score, 32'd7);
        playGame("game2", 3);
        checkValue("hs_game2", high_score, 32'd7);
        playGame("game3", 12);
        checkValue("hs_game3", high_score, 32'd12);
`else
        checkValue("hs_game1", high_score, 32'd0);
        playGame("game2", 3);
        checkValue("hs_game2", high_score, 32'd0);
        playGame("game3", 12);
        checkValue("hs_game3", high_score, 32'd0);
`endif

        // Reset while playing at score 9.
        applyStimulus("mid_start", 1, 0, 0, 0, 9);
        applyStimulus("mid_play", 0, 0, 0, 0, 9);
        @(negedge clk);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_reset");
        checkValue("mid_reset.state", 32'(game_state), 32'h1);
        checkValue("mid_reset.high", high_score, 32'd0);
        checkValue("mid_reset.over", 32'(game_over), 32'd0);
        @(posedge clk);
        #1;
        checkValue("mid_reset.over_hold", 32'(game_over), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("post_reset", 0, 0, 0, 0, 9);

        // Randomized play.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("random",
                          ($urandom % 3) == 0,
                          ($urandom % 4) == 0,
                          ($urandom % 10) == 0,
                          ($urandom % 2) == 0,
                          SW'($urandom_range(0, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
